// File: rtl/writer.sv
// writer: Avalon-MM master that writes one NDWORDS-word record, as 16-bit halfwords,
// into SDRAM slot `index` of an array starting at `baseaddr`.
module writer #(
    parameter int NDWORDS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            baseaddr,
    input  logic [31:0]            index,
    input  logic                   write,
    input  logic [32*NDWORDS-1:0]  data,
    output logic                   iready,
    output logic                   o_done,
    output logic                   avm_m0_write,
    output logic [31:0]            avm_m0_address,
    output logic [15:0]            avm_m0_writedata,
    output logic [1:0]             avm_m0_byteenable,
    input  logic                   avm_m0_waitrequest
);
    localparam int KW = $clog2(2*NDWORDS + 1);
    typedef enum logic {IDLE, WRITE} state_t;
    state_t state, state_nx;
    logic [KW-1:0] k;
    logic [32*NDWORDS-1:0] rec;
    logic last;
    assign last = k == KW'(2*NDWORDS - 1);
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (state == IDLE) state_nx = write ? WRITE : IDLE;
        else state_nx = (!avm_m0_waitrequest && last) ? IDLE : WRITE;
    end
    always_comb begin
        iready = state == IDLE;
        avm_m0_write = state == WRITE;
    end
    // rec shifts down one halfword per accept so the presented halfword is always rec[15:0]
    always_ff @(posedge clk) begin
        if (reset) begin
            k <= '0;
            rec <= '0;
            avm_m0_address <= '0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (state == IDLE && write) begin
                k <= '0;
                rec <= data;
                avm_m0_address <= baseaddr + index * 32'(4*NDWORDS);
            end else if (state == WRITE && !avm_m0_waitrequest) begin
                if (last) o_done <= 1'b1;
                else begin
                    k <= k + KW'(1);
                    rec <= rec >> 16;
                    avm_m0_address <= avm_m0_address + 32'd2;
                end
            end
        end
    end
    assign avm_m0_writedata = rec[15:0];
    assign avm_m0_byteenable = 2'b11;
endmodule

// File: tb/tb_writer.sv
// tb_writer: directed and randomized records checked against a queue-based model of
// the expected halfword stream (address, data) for each request.
module tb_writer;
    localparam int N = 3;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic write = 1'b0;
    logic avm_m0_waitrequest = 1'b0;
    logic [31:0] baseaddr = '0;
    logic [31:0] index = '0;
    logic [32*N-1:0] data = '0;
    logic iready, o_done, avm_m0_write;
    logic [31:0] avm_m0_address;
    logic [15:0] avm_m0_writedata;
    logic [1:0] avm_m0_byteenable;
    int checks = 0;
    int errors = 0;
    logic [31:0] ea[$];
    logic [15:0] ed[$];

    writer #(.NDWORDS(N)) dut (
        .clk(clk), .reset(reset), .baseaddr(baseaddr), .index(index), .write(write),
        .data(data), .iready(iready), .o_done(o_done), .avm_m0_write(avm_m0_write),
        .avm_m0_address(avm_m0_address), .avm_m0_writedata(avm_m0_writedata),
        .avm_m0_byteenable(avm_m0_byteenable), .avm_m0_waitrequest(avm_m0_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Builds the expected halfword stream, then issues a one-cycle request.
    task automatic start(input logic [31:0] b, input logic [31:0] i, input logic [32*N-1:0] d);
        logic [31:0] w;
        ea.delete();
        ed.delete();
        for (int n = 0; n < 2*N; n++) begin
            w = d[32*(n/2) +: 32];
            ea.push_back(b + i * 32'(4*N) + 32'(2*n));
            ed.push_back((n % 2) ? w[31:16] : w[15:0]);
        end
        check("iready_before_req", 32'(iready), 1);
        baseaddr = b;
        index = i;
        data = d;
        write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    // Follows one transfer from the cycle after accept up to the o_done cycle.
    task automatic run(input int stall_at, input int stall_len, input int busy_at);
        int k = 0;
        int wcnt = 0;
        int st = 0;
        int cyc = 0;
        bit wr;
        while (k < 2*N && cyc < 200) begin
            wr = (k == stall_at) && (st < stall_len);
            if (wr) st++;
            avm_m0_waitrequest = wr;
            check("write_strobe", 32'(avm_m0_write), 1);
            check("iready_busy", 32'(iready), 0);
            check("no_early_done", 32'(o_done), 0);
            check("address", avm_m0_address, ea[k]);
            check("writedata", 32'(avm_m0_writedata), 32'(ed[k]));
            write = (cyc == busy_at);
            if (cyc == busy_at) begin
                index = 32'd5;
                data = {$urandom, $urandom, $urandom};
            end
            if (!wr) k++;
            wcnt++;
            cyc++;
            @(negedge clk);
        end
        avm_m0_waitrequest = 1'b0;
        write = 1'b0;
        check("halfwords_accepted", k, 2*N);
        check("write_cycles", wcnt, 2*N + ((stall_at < 2*N) ? stall_len : 0));
        check("done_pulse", 32'(o_done), 1);
        check("iready_at_done", 32'(iready), 1);
        check("write_low_at_done", 32'(avm_m0_write), 0);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check("idle_no_done", 32'(o_done), 0);
            check("idle_no_write", 32'(avm_m0_write), 0);
            check("idle_iready", 32'(iready), 1);
        end
    endtask

    initial begin
        logic [32*N-1:0] rd;
        repeat (2) @(negedge clk);
        check("rst_iready", 32'(iready), 1);
        check("rst_done", 32'(o_done), 0);
        check("rst_write", 32'(avm_m0_write), 0);
        check("rst_address", avm_m0_address, 0);
        check("rst_writedata", 32'(avm_m0_writedata), 0);
        check("rst_byteenable", 32'(avm_m0_byteenable), 3);
        reset = 1'b0;
        idle(1);
        // basic record
        start(32'h1000, 32'd2, {32'h55556666, 32'h33334444, 32'h11112222});
        check("basic_first_addr", avm_m0_address, 32'h1018);
        check("basic_first_data", 32'(avm_m0_writedata), 32'h2222);
        run(100, 0, -1);
        check("basic_last_addr_held", avm_m0_address, 32'h1022);
        idle(2);
        // stall on halfword 2
        start(32'h1000, 32'd2, {32'h55556666, 32'h33334444, 32'h11112222});
        run(2, 3, -1);
        idle(1);
        // busy request ignored
        start(32'h1000, 32'd2, {32'h55556666, 32'h33334444, 32'h11112222});
        run(100, 0, 1);
        idle(2);
        // reset after halfword 3 is accepted
        start(32'h1000, 32'd2, {32'h55556666, 32'h33334444, 32'h11112222});
        repeat (4) @(negedge clk);
        check("pre_reset_addr", avm_m0_address, 32'h1020);
        reset = 1'b1;
        write = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        write = 1'b0;
        check("abort_write_low", 32'(avm_m0_write), 0);
        check("abort_iready", 32'(iready), 1);
        check("abort_no_done", 32'(o_done), 0);
        idle(3);
        rd = {$urandom, $urandom, $urandom};
        start(32'h1000, 32'd0, rd);
        check("after_abort_addr", avm_m0_address, 32'h1000);
        run(100, 0, -1);
        idle(1);
        // address wrap, then back-to-back request in the o_done cycle
        rd = {$urandom, $urandom, $urandom};
        start(32'hFFFF_FFF8, 32'd1, rd);
        check("wrap_first_addr", avm_m0_address, 32'h4);
        run(100, 0, -1);
        check("wrap_last_addr", avm_m0_address, 32'hE);
        rd = {$urandom, $urandom, $urandom};
        start(32'h1000, 32'd3, rd);
        check("b2b_first_addr", avm_m0_address, 32'h1024);
        run(100, 0, -1);
        idle(1);
        // randomized records with random stalls and idle gaps
        for (int t = 0; t < 12; t++) begin
            rd = {$urandom, $urandom, $urandom};
            start($urandom, $urandom_range(0, 1000), rd);
            run($urandom_range(0, 2*N), $urandom_range(0, 3), -1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
